w5300_bus_ctrl: RTL and testbench

//  Register-access engine for the W5300 16-bit direct-mode parallel bus. It sits between the
//  W5300 config/socket FSMs, which issue {op, addr, data} requests using the W5300 package

---
 rtl/w5300_bus_ctrl_pkg.sv | 29 ++
 rtl/w5300_phase_timer.sv | 27 ++
 rtl/w5300_bus_ctrl.sv | 159 +++++++++++++++
 tb/tb_w5300_bus_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w5300_bus_ctrl_pkg.sv
// Shared types and default bus timing for the W5300 direct-mode register-access engine.
package w5300_bus_ctrl_pkg;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } AddrOperation;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER,
        ERR
    } BusState;

    localparam int BUS_T_SETUP = 1;
    localparam int BUS_T_RD    = 7;
    localparam int BUS_T_WR    = 6;
    localparam int BUS_T_HOLD  = 1;
    localparam int BUS_T_REC   = 3;

    // Phase counters count down to zero, so a phase of t cycles loads t-1.
    function automatic logic [3:0] phase_load(input int t);
        return 4'(t - 1);
    endfunction

endpackage

// File: rtl/w5300_phase_timer.sv
// 4-bit load/decrement counter shared by every timed bus phase; done while the count is zero.
module w5300_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] count_o,
    output logic       done_o
);

    logic [3:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == 4'd0);

endmodule

// File: rtl/w5300_bus_ctrl.sv
// W5300 16-bit direct-mode bus engine: turns {op, addr, data} requests into timed CSn/RDn/WRn cycles.
module w5300_bus_ctrl
    import w5300_bus_ctrl_pkg::*;
#(
    parameter int T_SETUP = BUS_T_SETUP,
    parameter int T_RD    = BUS_T_RD,
    parameter int T_WR    = BUS_T_WR,
    parameter int T_HOLD  = BUS_T_HOLD,
    parameter int T_REC   = BUS_T_REC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [9:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_rdata,
    output logic [9:0]  w5300_addr,
    output logic [15:0] w5300_data_o,
    output logic        w5300_data_oe,
    input  logic [15:0] w5300_data_i,
    output logic        w5300_cs_n,
    output logic        w5300_rd_n,
    output logic        w5300_wr_n
);

    BusState      state_q, state_d;
    AddrOperation op_q;
    logic [9:0]   addr_q;
    logic [15:0]  wdata_q;
    logic         accept;

    logic         timer_load;
    logic [3:0]   timer_load_val;
    logic [3:0]   timer_count;
    logic         timer_done;

    logic         cs_n_q, cs_n_d;
    logic         rd_n_q, rd_n_d;
    logic         wr_n_q, wr_n_d;
    logic         oe_q, oe_d;
    logic [9:0]   pin_addr_q, pin_addr_d;
    logic [15:0]  pin_data_q, pin_data_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_err_q, rsp_err_d;
    logic [15:0]  rsp_rdata_q, rsp_rdata_d;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    w5300_phase_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .count_o    (timer_count),
        .done_o     (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = req_addr[0] ? ERR : SETUP;
            SETUP:   if (timer_done) state_d = STROBE;
            STROBE:  if (timer_done) state_d = HOLD;
            HOLD:    if (timer_done) state_d = RECOVER;
            RECOVER: if (timer_done) state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values are decoded from the current state and land one cycle later in the pin registers.
    always_comb begin
        timer_load     = (state_d != state_q);
        timer_load_val = 4'd0;
        unique case (state_d)
            SETUP:   timer_load_val = phase_load(T_SETUP);
            STROBE:  timer_load_val = (op_q == OP_WR) ? phase_load(T_WR) : phase_load(T_RD);
            HOLD:    timer_load_val = phase_load(T_HOLD);
            RECOVER: timer_load_val = phase_load(T_REC);
            default: timer_load_val = 4'd0;
        endcase

        cs_n_d      = (state_q != STROBE);
        rd_n_d      = !((state_q == STROBE) && (op_q == OP_RD));
        wr_n_d      = !((state_q == STROBE) && (op_q == OP_WR));
        oe_d        = (op_q == OP_WR) &&
                      ((state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD));
        pin_addr_d  = (state_q == SETUP) ? addr_q : pin_addr_q;
        pin_data_d  = ((state_q == SETUP) && (op_q == OP_WR)) ? wdata_q : pin_data_q;

        rsp_valid_d = (state_q == ERR) ||
                      ((state_q == RECOVER) && (timer_count == phase_load(T_REC)));
        rsp_err_d   = (state_q == ERR);
        // Sample read data on the last cycle RDn is low, i.e. when it is about to rise.
        rsp_rdata_d = (!rd_n_q && rd_n_d) ? w5300_data_i : rsp_rdata_q;
    end

    // NOTE: only storage that is observable after reset is reset; everything here is small and resettable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_RD;
            addr_q  <= 10'd0;
            wdata_q <= 16'd0;
        end else if (accept) begin
            op_q    <= AddrOperation'(req_op);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            pin_addr_q  <= 10'd0;
            pin_data_q  <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 16'd0;
        end else begin
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            oe_q        <= oe_d;
            pin_addr_q  <= pin_addr_d;
            pin_data_q  <= pin_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign w5300_cs_n    = cs_n_q;
    assign w5300_rd_n    = rd_n_q;
    assign w5300_wr_n    = wr_n_q;
    assign w5300_data_oe = oe_q;
    assign w5300_addr    = pin_addr_q;
    assign w5300_data_o  = pin_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_w5300_bus_ctrl.sv
// Scoreboard bench for w5300_bus_ctrl: random register traffic against a W5300 pin model and a memory model.
module tb_w5300_bus_ctrl;
    import w5300_bus_ctrl_pkg::*;

    localparam int TS  = 1;
    localparam int TRD = 7;
    localparam int TWR = 6;
    localparam int TH  = 1;
    localparam int TR  = 3;

    logic        clk, rst;
    logic        req_valid, req_ready, req_op;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [9:0]  w5300_addr;
    logic [15:0] w5300_data_o, w5300_data_i;
    logic        w5300_data_oe, w5300_cs_n, w5300_rd_n, w5300_wr_n;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        logic [15:0] wdata;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] ref_mem [512];
    logic [15:0] dev_mem [512];
    logic [15:0] last_rdata;
    int          cycle;
    int          n_checks;
    int          n_pass;
    int          last_rsp_cycle;
    int          run;
    logic        was_rd;
    logic        prev_cs;
    logic [9:0]  prev_addr;

    w5300_bus_ctrl #(
        .T_SETUP (TS), .T_RD (TRD), .T_WR (TWR), .T_HOLD (TH), .T_REC (TR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rsp_rdata     (rsp_rdata),
        .w5300_addr    (w5300_addr),
        .w5300_data_o  (w5300_data_o),
        .w5300_data_oe (w5300_data_oe),
        .w5300_data_i  (w5300_data_i),
        .w5300_cs_n    (w5300_cs_n),
        .w5300_rd_n    (w5300_rd_n),
        .w5300_wr_n    (w5300_wr_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    // W5300 pin model: word-addressed register file behind the bus.
    assign w5300_data_i = (!w5300_cs_n && !w5300_rd_n) ? dev_mem[w5300_addr[9:1]] : 16'h0000;
    always @(posedge clk) begin
        if (!rst && !w5300_cs_n && !w5300_wr_n && w5300_data_oe)
            dev_mem[w5300_addr[9:1]] = w5300_data_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        else
            n_pass = n_pass + 1;
    endtask

    // Monitor: bus-protocol checks and the response scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            run            = 0;
            prev_cs        = 1'b1;
            prev_addr      = w5300_addr;
            last_rsp_cycle = -1000;
        end else begin
            if (!w5300_rd_n) check("oe_during_rd", 32'(w5300_data_oe), 0);
            if (!w5300_wr_n && exp_q.size() != 0) begin
                check("wr_oe", 32'(w5300_data_oe), 1);
                check("wr_data", 32'(w5300_data_o), 32'(exp_q[0].wdata));
            end
            if (!w5300_cs_n) begin
                if (prev_cs) begin
                    check("addr_setup", 32'(w5300_addr), 32'(prev_addr));
                    check("recovery_gap", 32'(cycle - last_rsp_cycle >= TR + TS), 1);
                    was_rd = !w5300_rd_n;
                    run    = 0;
                end
                run = run + 1;
            end else if (!prev_cs) begin
                if (was_rd) check("rd_strobe_len", run, TRD);
                else        check("wr_strobe_len", run, TWR);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                    check("rsp_latency", cycle - mon_e.acc, mon_e.lat);
                    check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                    if (mon_e.err) begin
                        check("err_no_cs", 32'(w5300_cs_n), 1);
                        check("err_back_idle", 32'(req_ready), 1);
                    end else begin
                        last_rsp_cycle = cycle;
                    end
                end
            end
            prev_cs   = w5300_cs_n;
            prev_addr = w5300_addr;
        end
    end

    // Present a request and wait for acceptance; the expected response is queued from the memory model.
    task automatic issue(input logic op, input logic [9:0] a, input logic [15:0] d);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w = w + 1;
        end
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        e.acc   = cycle + 1;
        e.wdata = d;
        if (a[0]) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (op) begin
            ref_mem[a[9:1]] = d;
            e.err = 1'b0;
            e.lat = 1 + TS + TWR + TH;
        end else begin
            last_rdata = ref_mem[a[9:1]];
            e.err = 1'b0;
            e.lat = 1 + TS + TRD + TH;
        end
        e.rdata = last_rdata;
        exp_q.push_back(e);
    endtask

    task automatic release_req();
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 1'($urandom);
        req_addr  = 10'($urandom);
        req_wdata = 16'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || !req_ready) && w < 300) begin
            @(negedge clk);
            w = w + 1;
        end
        if (w >= 300) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        logic [9:0]  a;
        n_checks   = 0;
        n_pass     = 0;
        cycle      = 0;
        last_rdata = 16'h0000;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 1'b0;
        req_addr   = 10'd0;
        req_wdata  = 16'd0;
        for (int i = 0; i < 512; i++) begin
            v = 16'($urandom);
            ref_mem[i] = v;
            dev_mem[i] = v;
        end
        ref_mem[10'h0FE >> 1] = 16'h5300;
        dev_mem[10'h0FE >> 1] = 16'h5300;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(w5300_cs_n), 1);
        check("rst_rd_n", 32'(w5300_rd_n), 1);
        check("rst_wr_n", 32'(w5300_wr_n), 1);
        check("rst_oe", 32'(w5300_data_oe), 0);
        check("rst_addr", 32'(w5300_addr), 0);
        check("rst_data_o", 32'(w5300_data_o), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_ready", 32'(req_ready), 1);
        rst = 1'b0;

        // Idle after reset: pins quiet, ready, no responses
        repeat (20) @(negedge clk);
        check("idle_cs_n", 32'(w5300_cs_n), 1);
        check("idle_oe", 32'(w5300_data_oe), 0);
        check("idle_ready", 32'(req_ready), 1);

        // WR MR, RD IDR, readback of MR
        issue(1'b1, 10'h000, 16'h8000);
        release_req();
        drain();
        issue(1'b0, 10'h0FE, 16'h0000);
        release_req();
        drain();
        issue(1'b0, 10'h000, 16'h0000);
        release_req();
        drain();

        // Odd address is rejected
        issue(1'b0, 10'h0FF, 16'h0000);
        release_req();
        drain();

        // Back-to-back with req_valid held
        issue(1'b0, 10'h208, 16'h0000);
        @(negedge clk);
        check("ready_low_busy", 32'(req_ready), 0);
        issue(1'b1, 10'h202, 16'h0001);
        release_req();
        drain();

        // Reset in the 3rd STROBE cycle of a write
        issue(1'b1, 10'h3FC, 16'hA5A5);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_in_strobe", 32'(w5300_wr_n), 0);
        rst = 1'b1;
        #1;
        check("abort_cs_n", 32'(w5300_cs_n), 1);
        check("abort_wr_n", 32'(w5300_wr_n), 1);
        check("abort_oe", 32'(w5300_data_oe), 0);
        exp_q.delete();
        last_rdata = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        issue(1'b0, 10'h202, 16'h0000);
        release_req();
        drain();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            a    = 10'($urandom_range(0, 10'h2FF));
            a[0] = ($urandom_range(0, 7) == 0);
            issue(1'($urandom_range(0, 1)), a, 16'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                release_req();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        release_req();
        drain();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
